// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle ARMv4-subset datapath. Sequences fetch/decode/
// execute/memory/writeback and gates every architectural write by the condition field.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        is_mul
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_ORR   = 4'b0011;
    localparam logic [3:0] ALU_MUL   = 4'b0100;
    localparam logic [3:0] ALU_UMULL = 4'b0101;

    state_t     r_state;
    logic [3:0] r_nzcv;

    logic [1:0] w_op;
    logic [3:0] w_cmd;
    logic [3:0] w_cond;
    logic       w_s;
    logic       w_rd15;
    logic       w_is_mul;
    logic       w_is_umull;
    logic       w_is_cmp;
    logic       w_is_arith;
    logic       w_cond_ex;
    logic [3:0] w_alu_exec;
    logic       w_n, w_z, w_c, w_v;
    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_ir_write;
    logic       w_unused;

    assign w_op       = Instr[27:26];
    assign w_cmd      = Instr[24:21];
    assign w_cond     = Instr[31:28];
    assign w_s        = Instr[20];
    assign w_rd15     = (Instr[15:12] == 4'hF);
    assign w_is_mul   = (w_op == 2'b00) && !Instr[25] && (Instr[7:4] == 4'b1001);
    assign w_is_umull = w_is_mul && Instr[23];
    assign w_is_cmp   = !w_is_mul && (w_cmd == 4'b1010);
    assign w_is_arith = !w_is_mul && ((w_cmd == 4'b0100) || (w_cmd == 4'b0010) || (w_cmd == 4'b1010));
    assign {w_n, w_z, w_c, w_v} = r_nzcv;
    assign w_unused   = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = !w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = !w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = !w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = !w_v;
            4'b1000: w_cond_ex = w_c && !w_z;
            4'b1001: w_cond_ex = !w_c || w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = !w_z && (w_n == w_v);
            4'b1101: w_cond_ex = w_z || (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Multiply shares the op=00 space, so it must be recognised before the cmd field.
    always_comb begin
        w_alu_exec = ALU_ADD;
        if (w_is_mul) begin
            w_alu_exec = w_is_umull ? ALU_UMULL : ALU_MUL;
        end else begin
            case (w_cmd)
                4'b0100: w_alu_exec = ALU_ADD;
                4'b0010: w_alu_exec = ALU_SUB;
                4'b1010: w_alu_exec = ALU_SUB;
                4'b0000: w_alu_exec = ALU_AND;
                4'b1100: w_alu_exec = ALU_ORR;
                default: w_alu_exec = ALU_ADD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_nzcv  <= 4'b0000;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_cond_ex || (w_op == 2'b11))
                        r_state <= S_FETCH;
                    else if (w_op == 2'b01)
                        r_state <= S_MEMADR;
                    else if (w_op == 2'b10)
                        r_state <= S_BRANCH;
                    else
                        r_state <= Instr[25] ? S_EXECI : S_EXECR;
                end
                S_MEMADR: r_state <= Instr[20] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXECR, S_EXECI: begin
                    // Logical ops and multiplies keep the previous carry/overflow.
                    if (w_s) begin
                        r_nzcv[3:2] <= ALUFlags[3:2];
                        if (w_is_arith)
                            r_nzcv[1:0] <= ALUFlags[1:0];
                    end
                    r_state <= w_is_cmp ? S_FETCH : S_ALUWB;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_ir_write  = 1'b0;
        AdrSrc      = 1'b0;
        RegSrc      = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ImmSrc      = 2'b00;
        ALUControl  = ALU_ADD;
        is_mul      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegSrc    = {(w_op == 2'b01) && !Instr[20], (w_op == 2'b10)};
                ImmSrc    = (w_op == 2'b11) ? 2'b00 : w_op;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
                w_pc_write  = w_rd15;
            end
            S_MEMWR: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUControl = w_alu_exec;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_exec;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                is_mul      = w_is_umull;
                w_pc_write  = w_rd15 && !w_is_mul;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are suppressed combinationally so nothing commits on a reset edge.
    assign PCWrite  = w_pc_write  && !reset;
    assign MemWrite = w_mem_write && !reset;
    assign RegWrite = w_reg_write && !reset;
    assign IRWrite  = w_ir_write  && !reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed table, random instructions vs. a
// per-instruction cycle-sequence model, and reset-in-flight corner cases.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, is_mul;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [3:0]  ALUControl;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .is_mul(is_mul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0]  model_nzcv;
    logic [3:0]  model_next_nzcv;
    logic [19:0] exp_q[$];

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  flags;
        int          len;
        int          rw;
        int          mw;
        int          pcw;
        int          mul;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] obs_vec();
        return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ImmSrc, ALUControl, is_mul};
    endfunction

    function automatic logic [19:0] mk(input logic pcw, input logic mw, input logic rw,
                                       input logic irw, input logic adr, input logic [1:0] rsrc,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] res, input logic [1:0] imm,
                                       input logic [3:0] alu, input logic ml);
        return {pcw, mw, rw, irw, adr, rsrc, sa, sb, res, imm, alu, ml};
    endfunction

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected output vector for every cycle of one instruction, plus the flags it leaves.
    task automatic build_model(input logic [31:0] ins, input logic [3:0] nz, input logic [3:0] af);
        logic [1:0] op;
        logic [3:0] cmd, alu;
        bit mul, umull, arith, rd15;
        op   = ins[27:26];
        cmd  = ins[24:21];
        rd15 = (ins[15:12] == 4'hF);
        exp_q.delete();
        model_next_nzcv = nz;
        exp_q.push_back(mk(1,0,0,1,0,2'b00,2'b01,2'b10,2'b10,2'b00,4'd0,0));
        exp_q.push_back(mk(0,0,0,0,0,{op == 2'b01 && !ins[20], op == 2'b10},2'b01,2'b10,2'b10,
                           (op == 2'b11) ? 2'b00 : op,4'd0,0));
        if (!cond_holds(ins[31:28], nz) || op == 2'b11) return;
        if (op == 2'b01) begin
            exp_q.push_back(mk(0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,2'b00,4'd0,0));
            if (ins[20]) begin
                exp_q.push_back(mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,4'd0,0));
                exp_q.push_back(mk(rd15,0,1,0,0,2'b00,2'b00,2'b00,2'b01,2'b00,4'd0,0));
            end else begin
                exp_q.push_back(mk(0,1,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,4'd0,0));
            end
        end else if (op == 2'b10) begin
            exp_q.push_back(mk(1,0,0,0,0,2'b00,2'b00,2'b01,2'b10,2'b00,4'd0,0));
        end else begin
            mul   = !ins[25] && ins[7:4] == 4'b1001;
            umull = mul && ins[23];
            arith = !mul && (cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd10);
            if (mul) alu = umull ? 4'd5 : 4'd4;
            else case (cmd)
                4'b0010, 4'b1010: alu = 4'd1;
                4'b0000:          alu = 4'd2;
                4'b1100:          alu = 4'd3;
                default:          alu = 4'd0;
            endcase
            exp_q.push_back(mk(0,0,0,0,0,2'b00,2'b00,ins[25] ? 2'b01 : 2'b00,2'b00,2'b00,alu,0));
            if (ins[20]) begin
                model_next_nzcv[3:2] = af[3:2];
                if (arith) model_next_nzcv[1:0] = af[1:0];
            end
            if (!mul && cmd == 4'b1010) return;
            exp_q.push_back(mk(rd15 && !mul,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,4'd0,umull));
        end
    endtask

    // Runs one instruction from FETCH to the next FETCH, checking every cycle.
    task automatic exec_instr(input logic [31:0] ins, input logic [3:0] af,
                              output int len, output int rw, output int mw,
                              output int pcw, output int mul);
        logic [19:0] v;
        int cyc;
        bit done;
        build_model(ins, model_nzcv, af);
        Instr = ins;
        ALUFlags = af;
        #1;
        cyc = 0; done = 0; rw = 0; mw = 0; pcw = 0; mul = 0;
        while (!done) begin
            v = obs_vec();
            rw  += int'(RegWrite);
            mw  += int'(MemWrite);
            pcw += int'(PCWrite);
            mul += int'(is_mul);
            if (cyc < exp_q.size()) begin
                check($sformatf("instr_%h_cyc%0d", ins, cyc), 32'(v), 32'(exp_q[cyc]));
            end else begin
                total++;
                bad++;
                $display("FAIL overrun_%h: got extra cycle %0d, required %0d cycles", ins, cyc, exp_q.size());
            end
            step();
            cyc++;
            if (IRWrite === 1'b1 || cyc >= 12) done = 1;
        end
        len = cyc;
        check($sformatf("len_%h", ins), 32'(len), 32'(exp_q.size()));
        model_nzcv = model_next_nzcv;
        $display("instr %h flags %b cycles %0d nzcv %b", ins, af, len, model_nzcv);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [3:0] cond, rd, rn, rm, rs, cmd;
        logic s, ii;
        int k;
        cond = $urandom_range(0, 1) ? 4'hE : 4'($urandom_range(0, 15));
        rd = 4'($urandom); rn = 4'($urandom); rm = 4'($urandom); rs = 4'($urandom);
        s  = 1'($urandom);
        ii = 1'($urandom);
        k  = $urandom_range(0, 9);
        case (k)
            0, 1, 2, 3: begin
                case (k)
                    0: cmd = 4'b0100;
                    1: cmd = 4'b0010;
                    2: cmd = 4'b0000;
                    default: cmd = 4'b1100;
                endcase
                return {cond, 2'b00, ii, cmd, s, rn, rd, ii ? 12'($urandom) : {8'h00, rm}};
            end
            4: return {cond, 2'b00, ii, 4'b1010, 1'b1, rn, 4'h0, ii ? 12'($urandom) : {8'h00, rm}};
            5: return {cond, 7'b0000000, s, rd, 4'h0, rs, 4'b1001, rm};
            6: return {cond, 5'b00001, 2'b00, s, rd, rn, rs, 4'b1001, rm};
            7, 8: return {cond, 2'b01, 4'b0110, 1'b0, k == 7, rn, rd, 12'($urandom)};
            default: return {cond, 4'b1010, 24'($urandom)};
        endcase
    endfunction

    int len, rw, mw, pcw, mul;
    logic [31:0] ri;

    initial begin
        tbl[0]  = '{32'hE0812003, 4'b0000, 4, 1, 0, 1, 0}; // ADD R2,R1,R3
        tbl[1]  = '{32'hE1510001, 4'b0100, 3, 0, 0, 1, 0}; // CMP -> Z=1
        tbl[2]  = '{32'h0A000002, 4'b0000, 3, 0, 0, 2, 0}; // BEQ taken
        tbl[3]  = '{32'hE1510001, 4'b0000, 3, 0, 0, 1, 0}; // CMP -> Z=0
        tbl[4]  = '{32'h0A000002, 4'b0000, 2, 0, 0, 1, 0}; // BEQ not taken
        tbl[5]  = '{32'hE5910004, 4'b0000, 5, 1, 0, 1, 0}; // LDR
        tbl[6]  = '{32'hE5810000, 4'b0000, 4, 0, 1, 1, 0}; // STR
        tbl[7]  = '{32'hE0821394, 4'b1111, 4, 1, 0, 1, 1}; // UMULL, S=0
        tbl[8]  = '{32'h1A000002, 4'b0000, 3, 0, 0, 2, 0}; // BNE taken: flags kept
        tbl[9]  = '{32'hE081F003, 4'b0000, 4, 1, 0, 2, 0}; // ADD PC,...
        tbl[10] = '{32'hE1510001, 4'b0110, 3, 0, 0, 1, 0}; // CMP -> NZCV=0110
        tbl[11] = '{32'h10812003, 4'b0000, 2, 0, 0, 1, 0}; // ADDNE fails
        tbl[12] = '{32'hE0112003, 4'b0000, 4, 1, 0, 1, 0}; // ANDS -> 0010 (C held)
        tbl[13] = '{32'h2A000002, 4'b0000, 3, 0, 0, 2, 0}; // BCS taken
        tbl[14] = '{32'h0A000002, 4'b0000, 2, 0, 0, 1, 0}; // BEQ not taken
        tbl[15] = '{32'hF0812003, 4'b0000, 2, 0, 0, 1, 0}; // cond 1111 never

        reset = 1'b1;
        Instr = 32'h0;
        ALUFlags = 4'h0;
        model_nzcv = 4'h0;
        step();
        check("reset_strobes_c0", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'h0);
        step();
        check("reset_vec_c1", 32'(obs_vec()), 32'(mk(0,0,0,0,0,2'b00,2'b01,2'b10,2'b10,2'b00,4'd0,0)));
        reset = 1'b0;
        #1;

        for (int i = 0; i < 16; i++) begin
            exec_instr(tbl[i].instr, tbl[i].flags, len, rw, mw, pcw, mul);
            check($sformatf("tbl%0d_len", i), 32'(len), 32'(tbl[i].len));
            check($sformatf("tbl%0d_regwrite", i), 32'(rw), 32'(tbl[i].rw));
            check($sformatf("tbl%0d_memwrite", i), 32'(mw), 32'(tbl[i].mw));
            check($sformatf("tbl%0d_pcwrite", i), 32'(pcw), 32'(tbl[i].pcw));
            check($sformatf("tbl%0d_is_mul", i), 32'(mul), 32'(tbl[i].mul));
        end

        for (int i = 0; i < 250; i++) begin
            ri = gen_instr();
            exec_instr(ri, 4'($urandom), len, rw, mw, pcw, mul);
        end

        // Leave Z=1, then reset in the middle of a store.
        exec_instr(32'hE1510001, 4'b0100, len, rw, mw, pcw, mul);
        Instr = 32'hE5810000;
        ALUFlags = 4'h0;
        #1;
        check("memwr_seq_fetch", 32'(IRWrite), 32'h1);
        step();
        check("memwr_seq_decode_regsrc", 32'(RegSrc), 32'h2);
        step();
        step();
        check("memwr_before_reset", 32'(MemWrite), 32'h1);
        reset = 1'b1;
        #1;
        check("memwr_reset_memwrite", 32'(MemWrite), 32'h0);
        step();
        reset = 1'b0;
        #1;
        check("after_reset_fetch", 32'(obs_vec()), 32'(mk(1,0,0,1,0,2'b00,2'b01,2'b10,2'b10,2'b00,4'd0,0)));
        model_nzcv = 4'h0;
        exec_instr(32'h0A000002, 4'b0000, len, rw, mw, pcw, mul);
        check("beq_after_reset_len", 32'(len), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit that sequences the multicycle ARM datapath: fetch, decode, execute, memory and writeback steps.
- Decodes Instr into per-state control strobes and evaluates the condition field against an internal NZCV flags register.
- Gates all architectural writes by the condition result.
- Sits beside the datapath; its outputs drive the datapath select/enable inputs plus the memory write enable.

Parameters:
- none (fixed 32-bit ARMv4 subset: ADD, SUB, AND, ORR, CMP, MUL, UMULL, LDR, STR, B)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; returns controller to FETCH
Instr  input  32  instruction register contents from datapath
ALUFlags  input  4  {N,Z,C,V} from ALU, valid in execute states
PCWrite  output  1  PC register enable
MemWrite  output  1  data memory write enable
RegWrite  output  1  register file write enable
IRWrite  output  1  instruction register enable
AdrSrc  output  1  0=PC, 1=Result onto memory address
RegSrc  output  2  [0]=1 forces RA1=R15; [1]=1 selects Rd as RA2 (STR)
ALUSrcA  output  2  00=A register, 01=PC
ALUSrcB  output  2  00=WriteData, 01=ExtImm, 10=constant 4
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ImmSrc  output  2  00=8-bit DP imm, 01=12-bit mem offset, 10=24-bit branch
ALUControl  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 MUL, 0101 UMULL
is_mul  output  1  high in ALUWB for UMULL; enables RdHi write port

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. Reset sets state=FETCH and NZCV=0000.
- While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced 0.
- All other outputs are Moore-decoded from state plus Instr fields. Unlisted strobes are 0; unlisted selects are 00.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1. Always goes to DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=10, ResultSrc=10 (R15 reads PC+8).
  - RegSrc: [0]=1 for B; [1]=1 for STR.
  - ImmSrc from op field Instr[27:26].
  - CondEx is computed from Instr[31:28] and the current NZCV:
    - EQ..LE per ARM; AL=1110 is true; 1111 is false.
  - If CondEx=0, or op=11: go to FETCH. No write occurs and the instruction retires in 2 cycles.
  - Otherwise branch on op and fields:
    - op=01: MEMADR
    - op=10: BRANCH
    - op=00 with Instr[25]=0 and Instr[7:4]=1001: EXECR (multiply)
    - op=00 otherwise: Instr[25] ? EXECI : EXECR
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Next state: Instr[20] ? MEMRD : MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1; PCWrite=1 if Rd=15. Then FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=1. Then FETCH.
- EXECR / EXECI:
  - ALUSrcA=00; ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUControl from cmd Instr[24:21]:
    - 0100→ADD, 0010→SUB, 1010 (CMP)→SUB, 0000→AND, 1100→ORR
    - multiply: Instr[23] ? UMULL : MUL
  - Flags update at the clock edge ending this state when Instr[20]=1:
    - N and Z always load.
    - C and V load only for ADD/SUB/CMP.
    - Logical ops and multiplies hold C and V.
  - CMP goes to FETCH. All others go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, is_mul=(UMULL); PCWrite=1 if Rd=15 and not multiply. Then FETCH.
- BRANCH: ALUSrcA=00 (A=PC+8), ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1. Then FETCH.
- Latency in cycles: B=3, CMP=3, STR=4, DP=4, MUL/UMULL=4, LDR=5, condition-failed=2.
- Flags are written only in EXECR/EXECI, so flags set by instruction N are visible to the DECODE of instruction N+1.
- Reset asserted in any state: next state is FETCH on that edge, and no partial write completes in the reset cycle.

Test Plan:
- Reset held 2 cycles, then released with Instr=0xE0812003 (ADD R2,R1,R3):
  - states FETCH→DECODE→EXECR→ALUWB→FETCH
  - RegWrite=1 only in ALUWB; ALUControl=0000 in EXECR.
- CMP R1,R1 (0xE1510001) with ALUFlags=0100, then BEQ (0x0A000002):
  - NZCV=0100 after EXECR; BEQ sequence FETCH→DECODE→BRANCH with PCWrite=1 in BRANCH.
  - Repeat with ALUFlags=0000: BEQ returns DECODE→FETCH with no BRANCH.
- LDR R0,[R1,#4] (0xE5910004):
  - 5-cycle sequence; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB; MemWrite never 1.
- STR R0,[R1] (0xE5810000):
  - RegSrc[1]=1 in DECODE; MemWrite=1 only in MEMWR; RegWrite stays 0.
- UMULL (0xE0821394):
  - ALUControl=0101 in EXECR; is_mul=1 and RegWrite=1 in ALUWB; flags unchanged since S=0.
- Reset asserted during MEMWR: MemWrite=0 in that cycle and state=FETCH next cycle. Also ADD PC,... (Rd=15) sets PCWrite=1 in ALUWB.
